// File: rtl/step_ramp_pkg.sv
// step_ramp_pkg: shared state encoding and default widths for the step ramp scheduler
package step_ramp_pkg;
  localparam int DIVIDER_BITS_DEF = 16;
  localparam int RAMP_BITS_DEF = 8;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEL  = 2'd1,
    S_CRUISE = 2'd2,
    S_DECEL  = 2'd3
  } state_t;
endpackage

// File: rtl/step_period_timer.sv
// step_period_timer: free-running period counter; pulse (combinational) when count reaches period, then restarts at 0
// Ports: clk, reset (async, active-high), period, enable, restart; pulse.
module step_period_timer import step_ramp_pkg::*; #(
  parameter int W = DIVIDER_BITS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] period,
  input  logic         enable,
  input  logic         restart,
  output logic         pulse
);
  logic [W-1:0] count;
  // >= keeps the timer safe should the period ever shrink below the running count
  assign pulse = enable && !restart && count >= period;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= (restart || !enable || pulse) ? '0 : count + 1'b1;
endmodule

// File: rtl/step_ramp_scheduler.sv
// step_ramp_scheduler: trapezoidal step-rate scheduler (accelerate, cruise, decelerate) driving a step pulse
// Ports: clk, reset (async, active-high), start, stop, start_div, target_div, ramp_interval;
//        step, cur_div, state, busy, done, and step_count when STEP_RAMP_STEP_COUNT_EN is defined.
module step_ramp_scheduler import step_ramp_pkg::*; #(
  parameter int DIVIDER_BITS = DIVIDER_BITS_DEF,
  parameter int RAMP_BITS = RAMP_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [DIVIDER_BITS-1:0] start_div,
  input  logic [DIVIDER_BITS-1:0] target_div,
  input  logic [RAMP_BITS-1:0]    ramp_interval,
  output logic                    step,
  output logic [DIVIDER_BITS-1:0] cur_div,
  output logic [1:0]              state,
  output logic                    busy,
  output logic                    done
`ifdef STEP_RAMP_STEP_COUNT_EN
  ,
  output logic [31:0]             step_count
`endif
);
  state_t st;
  logic [DIVIDER_BITS-1:0] start_lat, target_lat, start_c, target_c, dn, up;
  logic [RAMP_BITS-1:0] ramp_lat, ramp_cnt;
  logic go, hit, group_done;
  assign start_c = start_div == '0 ? DIVIDER_BITS'(1) : start_div;
  assign target_c = target_div == '0 ? DIVIDER_BITS'(1) : target_div;
  assign go = st == S_IDLE && start && !stop;
  assign group_done = ramp_cnt == ramp_lat;
  // saturating neighbours so the divider can never wrap past the latched limits
  assign dn = cur_div > target_lat ? cur_div - 1'b1 : target_lat;
  assign up = cur_div < start_lat ? cur_div + 1'b1 : start_lat;
  assign state = st;
  assign busy = st != S_IDLE;
  step_period_timer #(.W(DIVIDER_BITS)) u_timer (
    .clk(clk), .reset(reset), .period(cur_div), .enable(busy), .restart(go), .pulse(hit)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= S_IDLE;
      step <= 1'b0;
      done <= 1'b0;
      cur_div <= '0;
      start_lat <= '0;
      target_lat <= '0;
      ramp_lat <= '0;
      ramp_cnt <= '0;
    end else begin
      step <= hit;
      done <= 1'b0;
      case (st)
        S_IDLE:
          if (go) begin
            start_lat <= start_c;
            target_lat <= target_c;
            ramp_lat <= ramp_interval;
            ramp_cnt <= '0;
            cur_div <= start_c;
            st <= start_c > target_c ? S_ACCEL : S_CRUISE;
          end
        S_ACCEL:
          if (stop) begin
            st <= S_DECEL;
            ramp_cnt <= '0;
          end else if (hit) begin
            ramp_cnt <= group_done ? '0 : ramp_cnt + 1'b1;
            if (group_done) begin
              cur_div <= dn;
              if (dn == target_lat) st <= S_CRUISE;
            end
          end
        S_CRUISE:
          if (stop) begin
            st <= S_DECEL;
            ramp_cnt <= '0;
          end
        S_DECEL:
          if (hit) begin
            if (cur_div >= start_lat) begin
              st <= S_IDLE;
              done <= 1'b1;
              ramp_cnt <= '0;
            end else begin
              ramp_cnt <= group_done ? '0 : ramp_cnt + 1'b1;
              if (group_done) cur_div <= up;
            end
          end
        default: st <= S_IDLE;
      endcase
    end
  end
`ifdef STEP_RAMP_STEP_COUNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) step_count <= '0;
    else if (go) step_count <= '0;
    else if (hit && step_count != '1) step_count <= step_count + 1'b1;
`endif
endmodule

// File: tb/tb_step_ramp_scheduler.sv
// tb_step_ramp_scheduler: randomized and directed self-checking bench against an absolute-time step schedule model
module tb_step_ramp_scheduler;
  localparam int DB = 16;
  localparam int RB = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [DB-1:0] start_div = '0, target_div = '0;
  logic [RB-1:0] ramp_interval = '0;
  logic step, busy, done;
  logic [DB-1:0] cur_div;
  logic [1:0] state;
`ifdef STEP_RAMP_STEP_COUNT_EN
  logic [31:0] step_count;
`endif
  step_ramp_scheduler #(.DIVIDER_BITS(DB), .RAMP_BITS(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .start_div(start_div), .target_div(target_div), .ramp_interval(ramp_interval),
    .step(step), .cur_div(cur_div), .state(state), .busy(busy), .done(done)
`ifdef STEP_RAMP_STEP_COUNT_EN
    , .step_count(step_count)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int e = 0, t0 = 0, n_done = 0;
  int m_ph, m_div, m_sd, m_td, m_ri, m_next, m_grp;
  bit m_step, m_done;
  longint m_cnt;
  int steps_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, e);
    end
  endtask
  function automatic void model_reset();
    m_ph = 0; m_div = 0; m_sd = 0; m_td = 0; m_ri = 0; m_next = 0; m_grp = 0;
    m_step = 0; m_done = 0; m_cnt = 0;
  endfunction
  // Model works on absolute edge numbers: the next step lands div+1 edges after the previous one.
  function automatic void model_edge(bit s, bit p);
    bit fire;
    e++;
    m_step = 0;
    m_done = 0;
    fire = 0;
    if (m_ph == 0) begin
      if (s && !p) begin
        m_sd = start_div == 0 ? 1 : int'(start_div);
        m_td = target_div == 0 ? 1 : int'(target_div);
        m_ri = int'(ramp_interval);
        m_div = m_sd;
        m_ph = m_sd > m_td ? 1 : 2;
        m_next = e + m_div + 1;
        m_grp = 0;
        m_cnt = 0;
        t0 = e;
        steps_q.delete();
      end
    end else begin
      fire = (e == m_next);
      if (fire) begin
        m_step = 1;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
      if ((m_ph == 1 || m_ph == 2) && p) begin
        m_ph = 3;
        m_grp = 0;
      end else if (fire) begin
        if (m_ph == 3 && m_div == m_sd) begin
          m_ph = 0;
          m_done = 1;
        end else if (m_ph != 2) begin
          m_grp++;
          if (m_grp == m_ri + 1) begin
            m_grp = 0;
            m_div += (m_ph == 1) ? -1 : 1;
            if (m_ph == 1 && m_div == m_td) m_ph = 2;
          end
        end
      end
      if (fire) m_next = e + m_div + 1;
    end
  endfunction
  task automatic check_all();
    chk("step", 32'(step), 32'(m_step));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("state", 32'(state), 32'(m_ph));
    chk("cur_div", 32'(cur_div), 32'(m_div));
`ifdef STEP_RAMP_STEP_COUNT_EN
    chk("step_count", step_count, 32'(m_cnt));
`endif
    if (step) steps_q.push_back(e);
    if (done) n_done++;
  endtask
  task automatic tick(input bit s, input bit p);
    start = s;
    stop = p;
    @(posedge clk);
    model_edge(s, p);
    @(negedge clk);
    check_all();
    start = 0;
    stop = 0;
  endtask
  task automatic run(input int n);
    repeat (n) tick(0, 0);
  endtask
  task automatic set_move(input int sd, input int td, input int ri);
    start_div = DB'(sd);
    target_div = DB'(td);
    ramp_interval = RB'(ri);
  endtask
  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      tick(0, 0);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask
  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_cur_div", 32'(cur_div), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_done", 32'(done), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask
  function automatic int period_at(input int i);
    if (steps_q.size() <= i) return -1;
    return i == 0 ? steps_q[0] - t0 : steps_q[i] - steps_q[i-1];
  endfunction
  initial begin
    int per[8];
    per = '{11, 11, 10, 10, 9, 9, 8, 8};
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 0);
    chk("reset_busy", 32'(busy), 0);
    reset = 0;
    run(3);
    set_move(10, 7, 1);
    tick(1, 0);
    run(100);
    for (int i = 0; i < 8; i++) chk("accel_period", 32'(period_at(i)), 32'(per[i]));
    chk("accel_cruise_period", 32'(period_at(9)), 8);
    chk("cruise_state", 32'(state), 2);
    n_done = 0;
    tick(0, 1);
    chk("decel_state", 32'(state), 3);
    wait_idle(300);
    run(20);
    chk("done_once", 32'(n_done), 1);
    set_move(5, 9, 0);
    tick(1, 0);
    chk("direct_cruise", 32'(state), 2);
    run(20);
    chk("direct_period", 32'(period_at(1)), 6);
    tick(0, 1);
    wait_idle(100);
    set_move(4, 2, 0);
    tick(1, 1);
    chk("start_stop_idle", 32'(state), 0);
    run(10);
    tick(1, 0);
    run(3);
    set_move(20, 1, 3);
    tick(1, 0);
    run(30);
    tick(0, 1);
    wait_idle(500);
    set_move(12, 3, 2);
    tick(1, 0);
    run(25);
    do_reset();
    n_done = 0;
    run(5);
    chk("reset_no_done", 32'(n_done), 0);
    set_move(0, 0, 0);
    tick(1, 0);
    run(12);
    chk("clamp_period", 32'(period_at(1)), 2);
    tick(0, 1);
    wait_idle(50);
`ifdef STEP_RAMP_STEP_COUNT_EN
    set_move(3, 3, 0);
    tick(1, 0);
    run(80);
    chk("count_20", step_count, 20);
    tick(0, 1);
    wait_idle(50);
    tick(1, 0);
    chk("count_clear", step_count, 0);
    tick(0, 1);
    wait_idle(50);
`endif
    for (int m = 0; m < 8; m++) begin
      set_move($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 2));
      tick(1, $urandom_range(0, 4) == 0);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 9) == 0)
          set_move($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 2));
        tick($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      end
      tick(0, 1);
      wait_idle(2000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/step_ramp_scheduler.md
STEP_RAMP_SCHEDULER -- requirements
Module: step_ramp_scheduler

Interface
REQ-001 SHALL have parameter DIVIDER_BITS, default 16: width of all period/divider values.
REQ-002 SHALL have parameter RAMP_BITS, default 8: width of ramp interval.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  begin a move (IDLE only).
REQ-006 SHALL have port stop  in  1  request controlled deceleration.
REQ-007 SHALL have port start_div  in  DIVIDER_BITS  initial (slowest) period, latched at start.
REQ-008 SHALL have port target_div  in  DIVIDER_BITS  cruise (fastest) period, latched at start.
REQ-009 SHALL have port ramp_interval  in  RAMP_BITS  steps between divider changes, minus one; latched at start.
REQ-010 SHALL have port step  out  1  one-cycle step pulse.
REQ-011 SHALL have port cur_div  out  DIVIDER_BITS  active period value.
REQ-012 SHALL have port state  out  2  IDLE=0, ACCEL=1, CRUISE=2, DECEL=3.
REQ-013 SHALL have ports busy (state!=IDLE) and done (one-cycle pulse on return to IDLE), each out 1.

Function
REQ-014 Period timer SHALL count 0..cur_div; at cur_div assert step for one cycle and restart at 0; step period = cur_div+1 cycles.
REQ-015 Latched divider values of 0 SHALL be clamped to 1.
REQ-016 IDLE + start (stop low): latch inputs, timer=0, cur_div=start_div; go ACCEL if start_div>target_div, else CRUISE with cur_div=start_div.
REQ-017 ACCEL: after every (ramp_interval+1) step pulses, cur_div decrements by 1 in the cycle of that pulse; cur_div reaching latched target -> CRUISE same cycle.
REQ-018 CRUISE: cur_div held constant; steps continue indefinitely until stop.
REQ-019 stop in ACCEL or CRUISE -> DECEL next cycle, ramp step count cleared, cur_div unchanged.
REQ-020 DECEL: after every (ramp_interval+1) steps, cur_div increments by 1; on the step pulse issued while cur_div==latched start_div -> IDLE and done pulse in the following cycle.
REQ-021 start while busy SHALL be ignored; stop in IDLE or DECEL SHALL be ignored.
REQ-022 start and stop both high in IDLE: stop wins, remain IDLE.
REQ-023 No step SHALL be emitted in IDLE; first step after start occurs cur_div+1 cycles after the start cycle.
REQ-024 Divider arithmetic SHALL never wrap: decrement saturates at target, increment saturates at start_div.

Reset
REQ-025 reset assertion SHALL immediately force: state=IDLE, step=0, done=0, busy=0, cur_div=0, timer=0, ramp count=0, latched values=0.
REQ-026 reset mid-move SHALL abort without a done pulse; first start after release behaves as REQ-016.

Configuration
REQ-027 Macro STEP_RAMP_STEP_COUNT_EN: when defined, add output step_count (32 bits) counting steps since last start (cleared at start, saturates at all-ones, held in IDLE); when undefined, port and counter SHALL be absent.

Structure
REQ-028 Shared package step_ramp_pkg SHALL hold the state encoding constants and default widths.
REQ-029 Period timer SHALL be a sub-module step_period_timer (inputs period, enable, restart; output pulse), reusable by other motion blocks.

Verification
REQ-030 start_div=10, target_div=7, ramp_interval=1, start -> periods 11,11,10,10,9,9,8,8 cycles, then CRUISE at cur_div=7 (period 8).
REQ-031 In CRUISE (div 7) assert stop -> DECEL; periods ramp back to 11 in pairs; done pulses once; busy drops; step stops.
REQ-032 start_div=5, target_div=9 -> direct CRUISE at cur_div=5, period 6 cycles.
REQ-033 start and stop high together in IDLE -> state stays 0, no step; start during ACCEL -> no effect on latched values.
REQ-034 Assert reset mid-ACCEL -> all outputs 0 immediately, no done; start_div=0 -> clamped, period 2 cycles.
REQ-035 With STEP_RAMP_STEP_COUNT_EN: 20 steps after start -> step_count=20; new start clears to 0.
